pipelined_control_unit: RTL

Parametrised decode-and-control block for the 5-stage MIPS pipeline. It decodes `op`/`func` in ID and carries the control bundle plus the destination register through the ID/EXE, EXE/MEM and MEM/WB stage registers. It also generates the forwarding selects for both ALU operands and the load-use stall. It replaces the purely combinational decoder, and the datapath consumes its per-stage outputs directly.

---
 rtl/pipelined_control_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pipelined_control_unit.sv
// ============================================================================
// Module : pipelined_control_unit
// Brief  : MIPS ID decode with EXE/MEM/WB control stage registers, forwarding and load-use stall.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipelined_control_unit #(
  parameter int REG_W      = 5,
  parameter int ALUC_W     = 4,
  parameter bit ENABLE_FWD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  output logic              wreg,
  output logic              m2reg,
  output logic              wmem,
  output logic              aluimm,
  output logic              regrt,
  output logic [ALUC_W-1:0] aluc,
  output logic              illegal,
  output logic              stall,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic              ewreg,
  output logic              em2reg,
  output logic              ewmem,
  output logic              ealuimm,
  output logic [ALUC_W-1:0] ealuc,
  output logic [REG_W-1:0]  ern,
  output logic              mwreg,
  output logic              mm2reg,
  output logic              mwmem,
  output logic [REG_W-1:0]  mrn,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [REG_W-1:0]  wrn
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_FN_ADD   = 6'b100000;
  localparam logic [5:0] c_FN_SUB   = 6'b100010;
  localparam logic [5:0] c_FN_AND   = 6'b100100;
  localparam logic [5:0] c_FN_OR    = 6'b100101;
  localparam logic [5:0] c_FN_SLT   = 6'b101010;

  logic [3:0]       w_aluc4;
  logic             w_uses_rt;
  logic [REG_W-1:0] w_rn;

  always_comb begin
    wreg      = 1'b0;
    m2reg     = 1'b0;
    wmem      = 1'b0;
    aluimm    = 1'b0;
    regrt     = 1'b0;
    w_aluc4   = 4'b0000;
    illegal   = 1'b1;
    w_uses_rt = 1'b0;
    case (op)
      c_OP_RTYPE: begin
        case (func)
          c_FN_ADD: begin w_aluc4 = 4'b0010; illegal = 1'b0; end
          c_FN_SUB: begin w_aluc4 = 4'b0110; illegal = 1'b0; end
          c_FN_AND: begin w_aluc4 = 4'b0000; illegal = 1'b0; end
          c_FN_OR:  begin w_aluc4 = 4'b0001; illegal = 1'b0; end
          c_FN_SLT: begin w_aluc4 = 4'b0111; illegal = 1'b0; end
          default:  ;
        endcase
        wreg      = !illegal;
        w_uses_rt = !illegal;
      end
      c_OP_LW: begin
        wreg = 1'b1; m2reg = 1'b1; aluimm = 1'b1; regrt = 1'b1;
        w_aluc4 = 4'b0010; illegal = 1'b0;
      end
      c_OP_SW: begin
        wmem = 1'b1; aluimm = 1'b1; regrt = 1'b1;
        w_aluc4 = 4'b0010; illegal = 1'b0; w_uses_rt = 1'b1;
      end
      c_OP_ADDI: begin
        wreg = 1'b1; aluimm = 1'b1; regrt = 1'b1;
        w_aluc4 = 4'b0010; illegal = 1'b0;
      end
      default: ;
    endcase
  end

  assign aluc = ALUC_W'(w_aluc4);
  // Illegal instructions travel as a full bubble, destination included.
  assign w_rn = illegal ? '0 : (regrt ? rt : rd);

  logic ewreg_q, em2reg_q, ewmem_q, ealuimm_q;
  logic [ALUC_W-1:0] ealuc_q;
  logic [REG_W-1:0]  ern_q, mrn_q, wrn_q;
  logic mwreg_q, mm2reg_q, mwmem_q, wwreg_q, wm2reg_q;

  // Source hits; gating by legality makes illegal instructions read nothing.
  logic w_e_rs, w_e_rt, w_m_rs, w_m_rt;
  assign w_e_rs = !illegal   && ewreg_q && (ern_q != '0) && (ern_q == rs);
  assign w_e_rt = w_uses_rt  && ewreg_q && (ern_q != '0) && (ern_q == rt);
  assign w_m_rs = !illegal   && mwreg_q && (mrn_q != '0) && (mrn_q == rs);
  assign w_m_rt = w_uses_rt  && mwreg_q && (mrn_q != '0) && (mrn_q == rt);

  if (ENABLE_FWD) begin : g_fwd
    assign stall = em2reg_q && (w_e_rs || w_e_rt);
    assign fwda  = (w_e_rs && !em2reg_q) ? 2'b01 :
                   (w_m_rs && !mm2reg_q) ? 2'b10 :
                   (w_m_rs &&  mm2reg_q) ? 2'b11 : 2'b00;
    assign fwdb  = (w_e_rt && !em2reg_q) ? 2'b01 :
                   (w_m_rt && !mm2reg_q) ? 2'b10 :
                   (w_m_rt &&  mm2reg_q) ? 2'b11 : 2'b00;
  end else begin : g_nofwd
    assign stall = w_e_rs || w_e_rt || w_m_rs || w_m_rt;
    assign fwda  = 2'b00;
    assign fwdb  = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ewreg_q <= 1'b0; em2reg_q <= 1'b0; ewmem_q <= 1'b0; ealuimm_q <= 1'b0;
      ealuc_q <= '0;   ern_q <= '0;
      mwreg_q <= 1'b0; mm2reg_q <= 1'b0; mwmem_q <= 1'b0; mrn_q <= '0;
      wwreg_q <= 1'b0; wm2reg_q <= 1'b0; wrn_q <= '0;
    end else begin
      ewreg_q   <= stall ? 1'b0 : wreg;
      em2reg_q  <= stall ? 1'b0 : m2reg;
      ewmem_q   <= stall ? 1'b0 : wmem;
      ealuimm_q <= stall ? 1'b0 : aluimm;
      ealuc_q   <= stall ? '0   : aluc;
      ern_q     <= stall ? '0   : w_rn;
      mwreg_q   <= ewreg_q;
      mm2reg_q  <= em2reg_q;
      mwmem_q   <= ewmem_q;
      mrn_q     <= ern_q;
      wwreg_q   <= mwreg_q;
      wm2reg_q  <= mm2reg_q;
      wrn_q     <= mrn_q;
    end
  end

  assign ewreg   = ewreg_q;
  assign em2reg  = em2reg_q;
  assign ewmem   = ewmem_q;
  assign ealuimm = ealuimm_q;
  assign ealuc   = ealuc_q;
  assign ern     = ern_q;
  assign mwreg   = mwreg_q;
  assign mm2reg  = mm2reg_q;
  assign mwmem   = mwmem_q;
  assign mrn     = mrn_q;
  assign wwreg   = wwreg_q;
  assign wm2reg  = wm2reg_q;
  assign wrn     = wrn_q;

endmodule

`default_nettype wire
